core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  begin execution; sampled only in IDLE.
REQ-004 SHALL have ports: mem_read, mem_write, reg_write, branch  in  1 each  decoded controls for the current IR; valid from DECODE onward.
REQ-005 SHALL have ports: instr_zero  in  1  current IR is all-zero (halt marker).
REQ-006 SHALL have ports: alu_zero  in  1  ALU zero flag; valid in EXECUTE.
REQ-007 SHALL have ports: imem_req  out  1  instruction fetch request; imem_ready  in  1  fetch data valid this cycle.
REQ-008 SHALL have ports: dmem_req  out  1  data access request; dmem_we  out  1  write when 1; dmem_ready  in  1  access complete this cycle.
REQ-009 SHALL have ports: ir_load  out  1  capture fetched word into IR.
REQ-010 SHALL have ports: pc_write  out  1  update PC; pc_src  out  1  0 = PC+4, 1 = branch target.
REQ-011 SHALL have ports: rf_we  out  1  register-file write; wb_sel  out  1  0 = ALU result, 1 = load data.
REQ-012 SHALL have ports: state  out  3  current state; halted  out  1  core stopped; instr_count  out  32  retired instructions.

Function
REQ-013 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6; codes 7 SHALL go to IDLE.
REQ-014 IDLE: start=1 -> FETCH; else stay.
REQ-015 FETCH: imem_req=1 every cycle; on imem_ready=1, ir_load=1 that cycle and -> DECODE; else stay, request held.
REQ-016 DECODE: one cycle; instr_zero=1 -> HALT; else -> EXECUTE.
REQ-017 EXECUTE: one cycle; mem_read|mem_write -> MEM; else reg_write -> WB; else retire here and -> FETCH.
REQ-018 EXECUTE retire: pc_write=1; pc_src=branch&alu_zero (combinational), else 0.
REQ-019 MEM: dmem_req=1 held until dmem_ready; dmem_we=mem_write&~mem_read (mem_read has priority if both set).
REQ-020 MEM on dmem_ready: load -> WB; store retires (pc_write=1, pc_src=0) and -> FETCH.
REQ-021 WB: one cycle; rf_we=1, wb_sel=mem_read, pc_write=1, pc_src=0; -> FETCH.
REQ-022 pc_write SHALL pulse exactly once per retired instruction; rf_we at most once, never outside WB.
REQ-023 instr_count SHALL increment by 1 in each pc_write cycle; wraps 0xFFFFFFFF -> 0.
REQ-024 HALT: halted=1, all request/enable outputs 0; stays until reset; start ignored; instr_count frozen (halt marker not counted).
REQ-025 start outside IDLE SHALL be ignored; memory ready inputs outside their wait states SHALL be ignored.
REQ-026 All-zero control inputs (unknown opcode) SHALL retire as NOP in EXECUTE.
REQ-027 Every output not named as asserted in a state SHALL be 0 in that state.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, instr_count=0, all other outputs 0, regardless of clk.
REQ-029 Reset mid-FETCH/MEM SHALL drop the pending request without completing it; no retire counted.
REQ-030 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-031 Reset, start=1 one cycle, R-type, imem_ready=1 immediately -> states 1,2,3,5; rf_we=1, wb_sel=0, pc_write=1 in WB, 4th cycle after start; instr_count=1.
REQ-032 Load, dmem_ready delayed 3 cycles -> dmem_req=1 for 4 cycles, dmem_we=0, then WB with wb_sel=1, rf_we=1; instr_count +1.
REQ-033 Branch, alu_zero=1 -> EXECUTE: pc_write=1, pc_src=1, rf_we never 1; repeat with alu_zero=0 -> pc_src=0; both return to FETCH.
REQ-034 Store -> MEM: dmem_req=1, dmem_we=1; on dmem_ready pc_write=1, next state FETCH, no WB.
REQ-035 instr_zero=1 in DECODE -> state=6, halted=1; later start=1 pulses -> no change; instr_count unchanged.
REQ-036 rst_n=0 mid-MEM with dmem_req=1 -> dmem_req=0, state=0, instr_count=0 before next clk edge.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle core control sequencer: walks each instruction through
// fetch, decode, execute, optional memory access and optional write-back,
// and issues the per-cycle control strobes for the datapath. Strobes are
// decoded from the current state and the same-cycle handshake/flag inputs,
// because fetch capture, branch selection and memory completion must take
// effect in the cycle the ready/flag input is seen.
module core_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        branch,
    input  logic        instr_zero,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] count_r;

    logic imem_req_s;
    logic dmem_req_s;
    logic dmem_we_s;
    logic ir_load_s;
    logic pc_write_s;
    logic pc_src_s;
    logic rf_we_s;
    logic wb_sel_s;
    logic halted_s;

    // State register; reset returns to IDLE and abandons any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Retired-instruction counter: one step per PC update, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (pc_write_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Next-state selection and per-state control strobes (all low unless named).
    always_comb begin
        state_nxt_s = state_r;
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        ir_load_s   = 1'b0;
        pc_write_s  = 1'b0;
        pc_src_s    = 1'b0;
        rf_we_s     = 1'b0;
        wb_sel_s    = 1'b0;
        halted_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_load_s   = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (instr_zero) begin
                    state_nxt_s = S_HALT;
                end else begin
                    state_nxt_s = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (mem_read || mem_write) begin
                    state_nxt_s = S_MEM;
                end else if (reg_write) begin
                    state_nxt_s = S_WB;
                end else begin
                    // Branches, NOPs and unknown opcodes retire here.
                    pc_write_s  = 1'b1;
                    pc_src_s    = branch & alu_zero;
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                // A read wins when both access controls are set.
                dmem_we_s  = mem_write & ~mem_read;
                if (dmem_ready) begin
                    if (mem_read) begin
                        state_nxt_s = S_WB;
                    end else begin
                        pc_write_s  = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s     = 1'b1;
                wb_sel_s    = mem_read;
                pc_write_s  = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_HALT: begin
                halted_s    = 1'b1;
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign imem_req    = imem_req_s;
    assign dmem_req    = dmem_req_s;
    assign dmem_we     = dmem_we_s;
    assign ir_load     = ir_load_s;
    assign pc_write    = pc_write_s;
    assign pc_src      = pc_src_s;
    assign rf_we       = rf_we_s;
    assign wb_sel      = wb_sel_s;
    assign halted      = halted_s;
    assign state       = state_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: reset checks, a cycle-exact trace of one R-type
// instruction, a table of instruction classes, randomized instructions scored
// against per-instruction expectations, asynchronous reset mid-access, and halt.
module tb_core_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        instr_zero;
    logic        alu_zero;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        ir_load;
    logic        pc_write;
    logic        pc_src;
    logic        rf_we;
    logic        wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] instr_count;

    int total;
    int bad;
    longint exp_cnt;

    typedef struct {
        int cyc;
        int imem;
        int ir;
        int dreq;
        int dwe;
        int rf;
        int wbsel;
        int pcw;
        int pcsrc;
        int halt;
    } counts_t;

    typedef struct {
        string   name;
        logic    mr;
        logic    mw;
        logic    rw;
        logic    br;
        logic    az;
        int      fw;
        int      mwt;
        counts_t exp;
    } vec_t;

    vec_t vec [8];

    core_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .branch      (branch),
        .instr_zero  (instr_zero),
        .alu_zero    (alu_zero),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_counts(input string nm, input counts_t a, input counts_t e);
        chk({nm, ".cycles"}, 64'(a.cyc), 64'(e.cyc));
        chk({nm, ".imem_req"}, 64'(a.imem), 64'(e.imem));
        chk({nm, ".ir_load"}, 64'(a.ir), 64'(e.ir));
        chk({nm, ".dmem_req"}, 64'(a.dreq), 64'(e.dreq));
        chk({nm, ".dmem_we"}, 64'(a.dwe), 64'(e.dwe));
        chk({nm, ".rf_we"}, 64'(a.rf), 64'(e.rf));
        chk({nm, ".wb_sel"}, 64'(a.wbsel), 64'(e.wbsel));
        chk({nm, ".pc_write"}, 64'(a.pcw), 64'(e.pcw));
        chk({nm, ".pc_src"}, 64'(a.pcsrc), 64'(e.pcsrc));
        chk({nm, ".halted"}, 64'(a.halt), 64'(e.halt));
    endtask

    // Reference: what one instruction must look like, from the class rules.
    function automatic counts_t model(input logic mr, input logic mw, input logic rw,
                                      input logic br, input logic az, input int fw, input int mwt);
        counts_t e;
        bit mem, load, store, wb;
        mem   = mr | mw;
        load  = mr;
        store = mw & ~mr;
        wb    = load | (~mem & rw);
        e.imem  = fw + 1;
        e.ir    = 1;
        e.dreq  = mem ? mwt + 1 : 0;
        e.dwe   = store ? mwt + 1 : 0;
        e.rf    = wb ? 1 : 0;
        e.wbsel = load ? 1 : 0;
        e.pcw   = 1;
        e.pcsrc = (~mem & ~rw & br & az) ? 1 : 0;
        e.halt  = 0;
        e.cyc   = (fw + 1) + 2 + e.dreq + e.rf;
        return e;
    endfunction

    // Run one instruction starting in FETCH (called just after a rising edge).
    // Ready inputs carry random noise wherever the design must ignore them.
    task automatic run_instr(input logic mr, input logic mw, input logic rw, input logic br,
                             input logic az, input int fw, input int mwt, output counts_t a);
        bit done;
        int dr_at;
        a = '{default: 0};
        done = 1'b0;
        dr_at = fw + 3 + mwt;
        mem_read = mr; mem_write = mw; reg_write = rw; branch = br;
        alu_zero = az; instr_zero = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start      = 1'($urandom % 2);
            imem_ready = (c == fw) ? 1'b1 : ((c > fw) ? 1'($urandom % 2) : 1'b0);
            if (c == dr_at) begin
                dmem_ready = 1'b1;
            end else if ((c < fw + 3) || (c > dr_at)) begin
                dmem_ready = 1'($urandom % 2);
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
            a.cyc++;
            if (imem_req === 1'b1) a.imem++;
            if (ir_load === 1'b1) a.ir++;
            if (dmem_req === 1'b1) a.dreq++;
            if (dmem_we === 1'b1) a.dwe++;
            if (rf_we === 1'b1) a.rf++;
            if (wb_sel === 1'b1) a.wbsel++;
            if (pc_src === 1'b1) a.pcsrc++;
            if (halted === 1'b1) a.halt++;
            if (pc_write === 1'b1) begin
                a.pcw++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        counts_t a;
        counts_t e;
        logic mr, mw, rw, br, az;
        int fw, mwt;

        total = 0; bad = 0; exp_cnt = 0;
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; branch = 1'b0; instr_zero = 1'b0; alu_zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;

        //                 name      mr    mw    rw    br    az   fw mwt   cyc im ir dq dw rf wbs pcw src hlt
        vec[0] = '{"rtype",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 0, 0, 1, 0, 1, 0, 0}};
        vec[1] = '{"load3",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, '{8, 1, 1, 4, 0, 1, 1, 1, 0, 0}};
        vec[2] = '{"store",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, '{5, 2, 1, 1, 1, 0, 0, 1, 0, 0}};
        vec[3] = '{"br_take", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, '{3, 1, 1, 0, 0, 0, 0, 1, 1, 0}};
        vec[4] = '{"br_not",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, '{5, 3, 1, 0, 0, 0, 0, 1, 0, 0}};
        vec[5] = '{"nop",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, '{3, 1, 1, 0, 0, 0, 0, 1, 0, 0}};
        vec[6] = '{"rd_wr",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, '{6, 1, 1, 2, 0, 1, 1, 1, 0, 0}};
        vec[7] = '{"br_rw",   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, '{4, 1, 1, 0, 0, 1, 0, 1, 0, 0}};

        // Reset state, with clock and noise on the inputs.
        #3;
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.count", 64'(instr_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        chk("rst.outs", 64'({imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_src,
                             rf_we, wb_sel, halted, state}), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Stay in IDLE without start; ready inputs ignored.
        repeat (3) begin
            @(negedge clk);
            chk("idle.hold", 64'({state, imem_req, dmem_req, pc_write}), 64'd0);
        end

        // Cycle-exact R-type trace.
        @(posedge clk); #1;
        start = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; reg_write = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("trace.fetch", 64'({state, imem_req, ir_load}), 64'({3'd1, 1'b1, 1'b1}));
        @(posedge clk); #1; imem_ready = 1'b0;
        @(negedge clk);
        chk("trace.decode", 64'(state), 64'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trace.exec", 64'({state, pc_write, rf_we}), 64'({3'd3, 1'b0, 1'b0}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("trace.wb", 64'({state, rf_we, wb_sel, pc_write}), 64'({3'd5, 1'b1, 1'b0, 1'b1}));
        @(posedge clk); #1;
        exp_cnt = 1;
        chk("trace.state_after", 64'(state), 64'd1);
        chk("trace.count", 64'(instr_count), 64'(exp_cnt));

        // Table of instruction classes.
        for (int i = 0; i < 8; i++) begin
            run_instr(vec[i].mr, vec[i].mw, vec[i].rw, vec[i].br, vec[i].az,
                      vec[i].fw, vec[i].mwt, a);
            cmp_counts(vec[i].name, a, vec[i].exp);
            exp_cnt++;
            chk({vec[i].name, ".count"}, 64'(instr_count), 64'(exp_cnt));
            chk({vec[i].name, ".next_fetch"}, 64'(state), 64'd1);
        end

        // Randomized instructions against the reference.
        for (int n = 0; n < 150; n++) begin
            mr = 1'($urandom % 2); mw = 1'($urandom % 2); rw = 1'($urandom % 2);
            br = 1'($urandom % 2); az = 1'($urandom % 2);
            fw = int'($urandom_range(0, 3)); mwt = int'($urandom_range(0, 4));
            e = model(mr, mw, rw, br, az, fw, mwt);
            run_instr(mr, mw, rw, br, az, fw, mwt, a);
            cmp_counts($sformatf("rnd%0d", n), a, e);
            exp_cnt++;
            chk($sformatf("rnd%0d.count", n), 64'(instr_count), 64'(exp_cnt));
            chk($sformatf("rnd%0d.next_fetch", n), 64'(state), 64'd1);
        end

        // Asynchronous reset while a load waits in MEM.
        mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; branch = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1; imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst.in_mem", 64'({state, dmem_req}), 64'({3'd4, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.dmem_req", 64'(dmem_req), 64'd0);
        chk("mrst.state", 64'(state), 64'd0);
        chk("mrst.count", 64'(instr_count), 64'd0);
        dmem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("mrst.idle", 64'({state, pc_write, rf_we}), 64'd0);
        chk("mrst.count_hold", 64'(instr_count), 64'd0);

        // Two instructions, then the halt marker.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, a);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, a);
        chk("halt.pre_count", 64'(instr_count), 64'd2);
        instr_zero = 1'b1; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("halt.state", 64'({state, halted}), 64'({3'd6, 1'b1}));
        for (int k = 0; k < 4; k++) begin
            start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
            mem_read = 1'($urandom % 2); reg_write = 1'b1; instr_zero = 1'($urandom % 2);
            @(negedge clk);
            chk("halt.stay", 64'({state, halted}), 64'({3'd6, 1'b1}));
            chk("halt.outs", 64'({imem_req, dmem_req, dmem_we, ir_load, pc_write,
                                  pc_src, rf_we, wb_sel}), 64'd0);
            chk("halt.count", 64'(instr_count), 64'd2);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
